// File: rtl/tcp_tx_arbiter.sv
// Round-robin whole-packet arbiter that streams NUM_SRC byte sources into the SiTCP TCP_TX port.
// Build macro ARB_HEADER_EN adds a 4-byte header (A5, index, len_hi, len_lo) before each payload.
module tcp_tx_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int LEN_W   = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ENABLE,
  input  logic [NUM_SRC-1:0]       SRC_REQ,
  input  logic [LEN_W*NUM_SRC-1:0] SRC_LEN,
  input  logic [8*NUM_SRC-1:0]     SRC_DATA,
  output logic [NUM_SRC-1:0]       SRC_RD,
  output logic [NUM_SRC-1:0]       SRC_DONE,
  output logic                     TCP_TX_WR,
  output logic [7:0]               TCP_TX_DATA,
  input  logic                     TCP_TX_FULL,
  output logic                     BUSY,
  output logic [2:0]               GRANT_IDX,
  output logic [31:0]              PKT_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
`ifdef ARB_HEADER_EN
    S_HDR,
`endif
    S_DATA,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       last_q, grant_q, cand, arb_idx;
  logic             found;
  logic [7:0]       req_pad;
  logic [LEN_W-1:0] rem_q, len_sel;
  logic [7:0]       data_sel;
  logic             pop;
  logic             tx_wr_q;
  logic [7:0]       tx_data_q;
  logic [31:0]      pkt_cnt_q;
`ifdef ARB_HEADER_EN
  logic [1:0]       hdr_cnt_q;
  logic             hdr_wr;
  logic [7:0]       hdr_byte;
  logic [15:0]      hdr_len;
`endif

  // Zero-padded to 8 so a 3-bit candidate index is always in range.
  assign req_pad = 8'(SRC_REQ);

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    found   = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = 3'((int'(last_q) + k) % NUM_SRC);
      if (!found && req_pad[cand]) begin
        found   = 1'b1;
        arb_idx = cand;
      end
    end
  end

  always_comb begin
    len_sel  = '0;
    data_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (arb_idx == 3'(i)) len_sel  = SRC_LEN[i*LEN_W +: LEN_W];
      if (grant_q == 3'(i)) data_sel = SRC_DATA[i*8 +: 8];
    end
  end

`ifdef ARB_HEADER_EN
  // rem still holds the full packet length while the header is being sent.
  always_comb begin
    hdr_wr  = !RST && (state_q == S_HDR) && !TCP_TX_FULL;
    hdr_len = 16'(rem_q);
    case (hdr_cnt_q)
      2'd0:    hdr_byte = 8'hA5;
      2'd1:    hdr_byte = {5'b0, grant_q};
      2'd2:    hdr_byte = hdr_len[15:8];
      default: hdr_byte = hdr_len[7:0];
    endcase
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (ENABLE && |SRC_REQ) state_d = S_ARB;
      S_ARB: begin
        if (!found) state_d = S_IDLE;
        else begin
`ifdef ARB_HEADER_EN
          state_d = S_HDR;
`else
          state_d = S_DATA;
`endif
        end
      end
`ifdef ARB_HEADER_EN
      S_HDR:  if (hdr_wr && hdr_cnt_q == 2'd3) state_d = S_DATA;
`endif
      S_DATA: if (rem_q == '0) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop      = !RST && (state_q == S_DATA) && (rem_q != '0) && !TCP_TX_FULL;
    SRC_RD   = '0;
    SRC_DONE = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      SRC_RD[i]   = pop && (grant_q == 3'(i));
      SRC_DONE[i] = (state_q == S_DONE) && (grant_q == 3'(i));
    end
    BUSY = (state_q != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q    <= 3'(NUM_SRC - 1);
      grant_q   <= '0;
      rem_q     <= '0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= '0;
      pkt_cnt_q <= '0;
`ifdef ARB_HEADER_EN
      hdr_cnt_q <= '0;
`endif
    end else begin
      if (state_q == S_ARB && found) begin
        grant_q <= arb_idx;
        rem_q   <= len_sel;
      end else if (pop) begin
        rem_q <= rem_q - LEN_W'(1);
      end
`ifdef ARB_HEADER_EN
      tx_wr_q <= pop | hdr_wr;
      if (pop)         tx_data_q <= data_sel;
      else if (hdr_wr) tx_data_q <= hdr_byte;
      if (state_q == S_ARB) hdr_cnt_q <= '0;
      else if (hdr_wr)      hdr_cnt_q <= hdr_cnt_q + 2'd1;
`else
      tx_wr_q <= pop;
      if (pop) tx_data_q <= data_sel;
`endif
      if (state_q == S_DONE) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
        last_q    <= grant_q;
      end
    end
  end

  assign TCP_TX_WR   = tx_wr_q;
  assign TCP_TX_DATA = tx_data_q;
  assign GRANT_IDX   = grant_q;
  assign PKT_CNT     = pkt_cnt_q;

endmodule
